cpu_ctrl_fsm: RTL and testbench

//  Multi-cycle control sequencer for the CPU datapath (pc, imem, regfile, alu, dmem).

---
 rtl/cpu_ctrl_pkg.sv | 69 ++++++
 rtl/cpu_ctrl_fsm_mem_req_timer.sv | 36 +++
 rtl/cpu_ctrl_fsm.sv | 172 +++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: state/trap encodings, opcode and ALU constants, and the ALU
// control decode shared by the control sequencer.
`default_nettype none

package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    TRAP_NONE    = 2'b00,
    TRAP_ILLEGAL = 2'b01,
    TRAP_IMEM    = 2'b10,
    TRAP_DMEM    = 2'b11
  } trap_cause_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_ALT    = 7'b0100000;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;

  function automatic logic opcode_legal(input logic [6:0] opc);
    logic legal;
    case (opc)
      OP_R, OP_I_ALU, OP_LOAD, OP_STORE, OP_BRANCH: legal = 1'b1;
      default:                                      legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic [3:0] alu_decode(input logic [6:0] opc,
                                            input logic [2:0] f3,
                                            input logic [6:0] f7);
    logic [3:0] op;
    op = ALU_ADD;
    case (opc)
      OP_R: begin
        if (f3 == 3'b000 && f7 == F7_ALT) op = ALU_SUB;
        else if (f3 == 3'b111)            op = ALU_AND;
        else if (f3 == 3'b110)            op = ALU_OR;
      end
      OP_I_ALU: begin
        if (f3 == 3'b111)      op = ALU_AND;
        else if (f3 == 3'b110) op = ALU_OR;
      end
      OP_BRANCH: op = ALU_SUB;
      default:   op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_ctrl_fsm_mem_req_timer.sv
// mem_req_timer: counts consecutive request cycles without acknowledge and
// flags the last permitted cycle.
`default_nettype none

module mem_req_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  // count holds the number of earlier unacknowledged cycles, so it reaches
  // LAST during request cycle LIMIT
  assign expired = (count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory
// handshakes, ALU control, retired-instruction counter and trap handling.
`default_nettype none

module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [31:0]      instr_in,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  input  logic             branch_taken,
  output logic             pc_en,
  output logic             pc_sel_branch,
  output logic [3:0]       alu_op,
  output logic             alu_src_imm,
  output logic             reg_write_en,
  output logic             wb_sel_mem,
  output logic             halted,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  state_e      state;
  state_e      state_next;
  trap_cause_e cause;
  trap_cause_e cause_next;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  logic timer_expired;
  logic req_any;
  logic ack_any;
  logic ctrl_active;
  logic is_load;
  logic is_store;
  logic unused_instr_bits;

  assign unused_instr_bits = ^{instr_in[24:15], instr_in[11:7]};

  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);

  // Only one request is ever outstanding, so a single timer serves both memories
  assign req_any = imem_req | dmem_req;
  assign ack_any = (imem_req & imem_ack) | (dmem_req & dmem_ack);

  mem_req_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (~req_any | ack_any),
    .en      (req_any & ~ack_any),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cause   <= TRAP_NONE;
      opcode  <= '0;
      funct3  <= '0;
      funct7  <= '0;
      instret <= '0;
    end else begin
      state <= state_next;
      cause <= cause_next;
      if (ir_we) begin
        opcode <= instr_in[6:0];
        funct3 <= instr_in[14:12];
        funct7 <= instr_in[31:25];
      end
      if (pc_en) begin
        instret <= instret + 1'b1;
      end
    end
  end

  always_comb begin
    state_next    = state;
    cause_next    = cause;
    imem_req      = 1'b0;
    ir_we         = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    pc_en         = 1'b0;
    pc_sel_branch = 1'b0;
    reg_write_en  = 1'b0;
    wb_sel_mem    = 1'b0;
    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we      = 1'b1;
          state_next = DECODE;
        end else if (timer_expired) begin
          state_next = TRAP;
          cause_next = TRAP_IMEM;
        end
      end
      DECODE: begin
        if (opcode_legal(opcode)) begin
          state_next = EXEC;
        end else begin
          state_next = TRAP;
          cause_next = TRAP_ILLEGAL;
        end
      end
      EXEC: begin
        case (opcode)
          OP_R, OP_I_ALU:    state_next = WB;
          OP_LOAD, OP_STORE: state_next = MEM;
          OP_BRANCH: begin
            pc_en         = 1'b1;
            pc_sel_branch = branch_taken;
            state_next    = FETCH;
          end
          default: begin
            state_next = TRAP;
            cause_next = TRAP_ILLEGAL;
          end
        endcase
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ack) begin
          if (is_load) begin
            state_next = WB;
          end else begin
            pc_en      = 1'b1;
            state_next = FETCH;
          end
        end else if (timer_expired) begin
          state_next = TRAP;
          cause_next = TRAP_DMEM;
        end
      end
      WB: begin
        reg_write_en = 1'b1;
        wb_sel_mem   = is_load;
        pc_en        = 1'b1;
        state_next   = FETCH;
      end
      TRAP:    state_next = TRAP;
      default: state_next = IDLE;
    endcase
  end

  // ALU control is held only while an instruction is in flight past fetch
  assign ctrl_active = (state == DECODE) || (state == EXEC) ||
                       (state == MEM)    || (state == WB);
  assign alu_op      = ctrl_active ? alu_decode(opcode, funct3, funct7) : ALU_ADD;
  assign alu_src_imm = ctrl_active &&
                       ((opcode == OP_I_ALU) || is_load || is_store);
  assign halted      = (state == TRAP);
  assign trap_cause  = cause;

endmodule

`default_nettype wire

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: directed scenario tests for the control sequencer with
// hand-computed cycle counts and strobe expectations.
`default_nettype none

module tb_cpu_ctrl_fsm;

  localparam int TO = 16;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          imem_req;
  logic          imem_ack = 1'b0;
  logic [31:0]   instr_in = '0;
  logic          ir_we;
  logic          dmem_req;
  logic          dmem_we;
  logic          dmem_ack = 1'b0;
  logic          branch_taken = 1'b0;
  logic          pc_en;
  logic          pc_sel_branch;
  logic [3:0]    alu_op;
  logic          alu_src_imm;
  logic          reg_write_en;
  logic          wb_sel_mem;
  logic          halted;
  logic [1:0]    trap_cause;
  logic [CW-1:0] instret;

  always #5 clk = ~clk;

  cpu_ctrl_fsm #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_ack(imem_ack), .instr_in(instr_in), .ir_we(ir_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .branch_taken(branch_taken), .pc_en(pc_en), .pc_sel_branch(pc_sel_branch),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .reg_write_en(reg_write_en),
    .wb_sel_mem(wb_sel_mem), .halted(halted), .trap_cause(trap_cause), .instret(instret)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int exp_instret = 0;

  // Per-instruction observations gathered by run_instr
  int   cyc, ir_cyc, req_cyc, dreq_cnt, dwe_cnt, rwe_cnt, rwe_cyc, pe_cnt, pe_cyc;
  logic wbsel, psel, alu_chg, first_req, ended_halt;
  logic [3:0] alu_dec;
  logic       src_dec;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_OR   = 32'h0020E1B3;
  localparam logic [31:0] I_ANDI = 32'h0050F093;
  localparam logic [31:0] I_LW   = 32'h0000A283;
  localparam logic [31:0] I_SW   = 32'h0050A023;
  localparam logic [31:0] I_BEQ  = 32'h00208063;
  localparam logic [31:0] I_ILL  = 32'h0000007F;

  // Starts at a falling edge with the DUT in FETCH; ends one falling edge after
  // the retiring cycle, trap entry, or the cycle budget.
  task automatic run_instr(input logic [31:0] instr, input int iwait,
                           input int dwait, input logic taken);
    int iw = 0;
    int dw = 0;
    bit done = 0;
    cyc = 0; ir_cyc = 0; req_cyc = 0; dreq_cnt = 0; dwe_cnt = 0;
    rwe_cnt = 0; rwe_cyc = 0; pe_cnt = 0; pe_cyc = 0;
    wbsel = 0; psel = 0; alu_chg = 0; first_req = 0; ended_halt = 0;
    alu_dec = '0; src_dec = 0;
    while (!done) begin
      cyc++;
      imem_ack = imem_req && (iw == iwait);
      if (imem_req) iw++;
      dmem_ack = dmem_req && (dw == dwait);
      if (dmem_req) dw++;
      instr_in = instr;
      branch_taken = taken;
      #1;
      if (cyc == 1) first_req = imem_req;
      if (ir_we) ir_cyc = cyc;
      if (imem_req) req_cyc++;
      if (dmem_req) dreq_cnt++;
      if (dmem_we) dwe_cnt++;
      if (reg_write_en) begin rwe_cnt++; rwe_cyc = cyc; wbsel = wb_sel_mem; end
      if (ir_cyc != 0 && cyc == ir_cyc + 1) begin alu_dec = alu_op; src_dec = alu_src_imm; end
      else if (ir_cyc != 0 && cyc > ir_cyc + 1 && !halted &&
               (alu_op !== alu_dec || alu_src_imm !== src_dec)) alu_chg = 1;
      if (pc_en) begin pe_cnt++; pe_cyc = cyc; psel = pc_sel_branch; done = 1; end
      if (halted) begin ended_halt = 1; done = 1; end
      if (cyc >= 200) done = 1;
      @(negedge clk);
    end
    imem_ack = 0; dmem_ack = 0; branch_taken = 0;
    if (pe_cnt != 0) exp_instret++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    exp_instret = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    @(negedge clk);
    #1;
    tests_run++;
    if ({imem_req, ir_we, dmem_req, dmem_we, pc_en, pc_sel_branch, alu_op, alu_src_imm,
         reg_write_en, wb_sel_mem, halted, trap_cause, instret} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: imem_req=%b pc_en=%b alu_op=%b halted=%b cause=%b instret=%0d, all required 0",
               imem_req, pc_en, alu_op, halted, trap_cause, instret);
    end
    @(negedge clk);
    reset = 1;
    #1;
    tests_run++;
    if (imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_release: imem_req=%b expected 0", imem_req);
    end
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL fetch_after_idle: imem_req=%b expected 1", imem_req);
    end
    exp_instret = 0;
  endtask

  task automatic test_add();
    run_instr(I_ADD, 0, 0, 0);
    tests_run++;
    if (first_req !== 1'b1 || ir_cyc != 1 || cyc != 4 || rwe_cyc != 4 || pe_cyc != 4) begin
      tests_failed++;
      $display("FAIL add_timing: req1=%b ir_cyc=%0d cycles=%0d rwe_cyc=%0d pe_cyc=%0d expected 1,1,4,4,4",
               first_req, ir_cyc, cyc, rwe_cyc, pe_cyc);
    end
    tests_run++;
    if (alu_dec !== 4'b0000 || src_dec !== 1'b0 || wbsel !== 1'b0 || alu_chg) begin
      tests_failed++;
      $display("FAIL add_ctrl: alu_op=%b src_imm=%b wb_sel_mem=%b unstable=%b expected 0000,0,0,0",
               alu_dec, src_dec, wbsel, alu_chg);
    end
    tests_run++;
    if (instret !== CW'(exp_instret) || exp_instret != 1) begin
      tests_failed++;
      $display("FAIL add_instret: got %0d expected 1", instret);
    end
  endtask

  task automatic test_sub_or();
    run_instr(I_SUB, 0, 0, 0);
    tests_run++;
    if (alu_dec !== 4'b0001 || alu_chg || cyc != 4 || rwe_cnt != 1) begin
      tests_failed++;
      $display("FAIL sub_ctrl: alu_op=%b unstable=%b cycles=%0d rwe=%0d expected 0001,0,4,1",
               alu_dec, alu_chg, cyc, rwe_cnt);
    end
    run_instr(I_OR, 0, 0, 0);
    tests_run++;
    if (alu_dec !== 4'b0011 || alu_chg || cyc != 4 || src_dec !== 1'b0) begin
      tests_failed++;
      $display("FAIL or_ctrl: alu_op=%b unstable=%b cycles=%0d src=%b expected 0011,0,4,0",
               alu_dec, alu_chg, cyc, src_dec);
    end
    run_instr(I_ANDI, 0, 0, 0);
    tests_run++;
    if (alu_dec !== 4'b0010 || src_dec !== 1'b1 || cyc != 4 || rwe_cnt != 1) begin
      tests_failed++;
      $display("FAIL andi_ctrl: alu_op=%b src=%b cycles=%0d rwe=%0d expected 0010,1,4,1",
               alu_dec, src_dec, cyc, rwe_cnt);
    end
    tests_run++;
    if (instret !== CW'(exp_instret)) begin
      tests_failed++;
      $display("FAIL alu_instret: got %0d expected %0d", instret, exp_instret);
    end
  endtask

  task automatic test_fetch_wait();
    run_instr(I_ADD, 2, 0, 0);
    tests_run++;
    if (req_cyc != 3 || ir_cyc != 3 || cyc != 6 || pe_cnt != 1) begin
      tests_failed++;
      $display("FAIL fetch_wait: req=%0d ir_cyc=%0d cycles=%0d pe=%0d expected 3,3,6,1",
               req_cyc, ir_cyc, cyc, pe_cnt);
    end
  endtask

  task automatic test_load_store();
    run_instr(I_LW, 0, 3, 0);
    tests_run++;
    if (dreq_cnt != 4 || dwe_cnt != 0 || cyc != 8 || rwe_cyc != 8 || wbsel !== 1'b1) begin
      tests_failed++;
      $display("FAIL load: dreq=%0d dwe=%0d cycles=%0d rwe_cyc=%0d wbsel=%b expected 4,0,8,8,1",
               dreq_cnt, dwe_cnt, cyc, rwe_cyc, wbsel);
    end
    tests_run++;
    if (alu_dec !== 4'b0000 || src_dec !== 1'b1 || alu_chg) begin
      tests_failed++;
      $display("FAIL load_alu: alu_op=%b src=%b unstable=%b expected 0000,1,0", alu_dec, src_dec, alu_chg);
    end
    run_instr(I_SW, 0, 3, 0);
    tests_run++;
    if (dreq_cnt != 4 || dwe_cnt != 4 || cyc != 7 || pe_cyc != 7 || rwe_cnt != 0) begin
      tests_failed++;
      $display("FAIL store: dreq=%0d dwe=%0d cycles=%0d pe_cyc=%0d rwe=%0d expected 4,4,7,7,0",
               dreq_cnt, dwe_cnt, cyc, pe_cyc, rwe_cnt);
    end
    run_instr(I_SW, 0, 0, 0);
    tests_run++;
    if (cyc != 4 || dreq_cnt != 1 || instret !== CW'(exp_instret)) begin
      tests_failed++;
      $display("FAIL store_fast: cycles=%0d dreq=%0d instret=%0d expected 4,1,%0d",
               cyc, dreq_cnt, instret, exp_instret);
    end
  endtask

  task automatic test_branch();
    run_instr(I_BEQ, 0, 0, 1);
    tests_run++;
    if (cyc != 3 || pe_cyc != 3 || psel !== 1'b1 || rwe_cnt != 0 || alu_dec !== 4'b0001) begin
      tests_failed++;
      $display("FAIL beq_taken: cycles=%0d pe_cyc=%0d sel=%b rwe=%0d alu=%b expected 3,3,1,0,0001",
               cyc, pe_cyc, psel, rwe_cnt, alu_dec);
    end
    run_instr(I_BEQ, 0, 0, 0);
    tests_run++;
    if (cyc != 3 || psel !== 1'b0 || rwe_cnt != 0 || dreq_cnt != 0) begin
      tests_failed++;
      $display("FAIL beq_not_taken: cycles=%0d sel=%b rwe=%0d dreq=%0d expected 3,0,0,0",
               cyc, psel, rwe_cnt, dreq_cnt);
    end
    tests_run++;
    if (instret !== CW'(exp_instret)) begin
      tests_failed++;
      $display("FAIL branch_instret: got %0d expected %0d", instret, exp_instret);
    end
  endtask

  task automatic test_dmem_timeout();
    run_instr(I_LW, 0, 1000, 0);
    tests_run++;
    if (!ended_halt || dreq_cnt != TO || trap_cause !== 2'b11 || pe_cnt != 0) begin
      tests_failed++;
      $display("FAIL dmem_timeout: halted=%b dreq=%0d cause=%b pe=%0d expected 1,%0d,11,0",
               ended_halt, dreq_cnt, trap_cause, pe_cnt, TO);
    end
  endtask

  task automatic test_illegal();
    apply_reset();
    run_instr(I_ILL, 0, 0, 0);
    repeat (3) @(negedge clk);
    tests_run++;
    if (halted !== 1'b1 || trap_cause !== 2'b01 || pe_cnt != 0 || cyc != 3 || instret !== '0) begin
      tests_failed++;
      $display("FAIL illegal: halted=%b cause=%b pe=%0d cycles=%0d instret=%0d expected 1,01,0,3,0",
               halted, trap_cause, pe_cnt, cyc, instret);
    end
  endtask

  task automatic test_imem_timeout();
    apply_reset();
    run_instr(I_ADD, 1000, 0, 0);
    tests_run++;
    if (!ended_halt || req_cyc != TO || cyc != TO + 1) begin
      tests_failed++;
      $display("FAIL imem_timeout_len: halted=%b req=%0d cycles=%0d expected 1,%0d,%0d",
               ended_halt, req_cyc, cyc, TO, TO + 1);
    end
    imem_ack = 1;
    dmem_ack = 1;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if ({imem_req, ir_we, dmem_req, dmem_we, pc_en, reg_write_en, wb_sel_mem, alu_op, alu_src_imm} !== '0 ||
        halted !== 1'b1 || trap_cause !== 2'b10) begin
      tests_failed++;
      $display("FAIL imem_timeout_trap: imem_req=%b pc_en=%b alu_op=%b halted=%b cause=%b expected 0,0,0000,1,10",
               imem_req, pc_en, alu_op, halted, trap_cause);
    end
    imem_ack = 0;
    dmem_ack = 0;
  endtask

  task automatic test_reset_mid_mem();
    apply_reset();
    run_instr(I_ADD, 0, 0, 0);
    tests_run++;
    if (instret !== 32'd1) begin
      tests_failed++;
      $display("FAIL pre_reset_instret: got %0d expected 1", instret);
    end
    instr_in = I_LW;
    imem_ack = 1;
    @(negedge clk);
    imem_ack = 0;
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if (dmem_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_mem_entered: dmem_req=%b expected 1", dmem_req);
    end
    reset = 0;
    #1;
    tests_run++;
    if (dmem_req !== 1'b0 || pc_en !== 1'b0 || reg_write_en !== 1'b0 || instret !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_mem: dmem_req=%b pc_en=%b rwe=%b instret=%0d expected 0,0,0,0",
               dmem_req, pc_en, reg_write_en, instret);
    end
    @(negedge clk);
    reset = 1;
    #1;
    tests_run++;
    if (imem_req !== 1'b0 || dmem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_mem_idle: imem_req=%b dmem_req=%b expected 0,0", imem_req, dmem_req);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (imem_req !== 1'b1 || instret !== '0) begin
      tests_failed++;
      $display("FAIL mid_mem_refetch: imem_req=%b instret=%0d expected 1,0", imem_req, instret);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_add();
    test_sub_or();
    test_fetch_wait();
    test_load_store();
    test_branch();
    test_dmem_timeout();
    test_illegal();
    test_imem_timeout();
    test_reset_mid_mem();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
